// File: rtl/l1_port_arbiter.sv
// ----------------------------------------------------------------------------
// l1_port_arbiter
//
// Shares one synchronous L1 block-RAM port between two requesters
// (req0: core load/store, req1: debug/loader bus). At most one beat is
// issued per cycle. Normal mode is round-robin. A requester can hold the
// port across a multi-beat atomic sequence by setting its lock bit. The
// read data comes back one cycle after issue. It is steered to the
// requester that issued the beat.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   reqN_valid/ready           request handshake (N = 0, 1)
//   reqN_we/lock/addr/be/wdata request fields, held stable until accepted
//   rspN_valid/rdata           response, one cycle after acceptance
//   mem_en/we/addr/be/wdata    memory port drive (same cycle as acceptance)
//   mem_rdata                  memory read data, one cycle after mem_en
// ----------------------------------------------------------------------------
module l1_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic                    req0_we,
    input  logic                    req0_lock,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic [DATA_WIDTH/8-1:0] req0_be,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    output logic                    rsp0_valid,
    output logic [DATA_WIDTH-1:0]   rsp0_rdata,

    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic                    req1_we,
    input  logic                    req1_lock,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic [DATA_WIDTH/8-1:0] req1_be,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    output logic                    rsp1_valid,
    output logic [DATA_WIDTH-1:0]   rsp1_rdata,

    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        RR    = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state_q;
    logic   ptr_q;        // 0: req0 wins a tie, 1: req1 wins a tie
    logic   rsp0_pend_q;  // beat from req0 issued last cycle
    logic   rsp1_pend_q;  // beat from req1 issued last cycle
    logic   gnt0;
    logic   gnt1;

    // Grants are combinational from the valids and the arbiter state. They
    // are forced low while reset is held, so nothing reaches the memory then.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a grant unassigned and infer a latch.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state_q)
                RR: begin
                    gnt0 = req0_valid & (~req1_valid | ~ptr_q);
                    gnt1 = req1_valid & (~req0_valid |  ptr_q);
                end
                LOCK0:   gnt0 = req0_valid;
                LOCK1:   gnt1 = req1_valid;
                default: ;
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Memory port: mux of the granted requester. When nothing is granted the
    // fields follow req0. That is harmless because mem_en and mem_we are low.
    assign mem_en    = gnt0 | gnt1;
    assign mem_we    = (gnt0 & req0_we) | (gnt1 & req1_we);
    assign mem_addr  = gnt1 ? req1_addr  : req0_addr;
    assign mem_be    = gnt1 ? req1_be    : req0_be;
    assign mem_wdata = gnt1 ? req1_wdata : req0_wdata;

    // The response is gated by reset. A beat accepted just before reset is
    // therefore never reported, even in the cycle where reset is asserted.
    assign rsp0_valid = rsp0_pend_q & ~reset;
    assign rsp1_valid = rsp1_pend_q & ~reset;
    assign rsp0_rdata = mem_rdata;
    assign rsp1_rdata = mem_rdata;

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together on the edge, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RR;
            ptr_q       <= 1'b0;
            rsp0_pend_q <= 1'b0;
            rsp1_pend_q <= 1'b0;
        end else begin
            rsp0_pend_q <= gnt0;
            rsp1_pend_q <= gnt1;
            // The lock bit is only looked at on granted beats. Idle cycles
            // leave both the state and the pointer untouched.
            if (gnt0) begin
                ptr_q   <= 1'b1;
                state_q <= req0_lock ? LOCK0 : RR;
            end else if (gnt1) begin
                ptr_q   <= 1'b0;
                state_q <= req1_lock ? LOCK1 : RR;
            end
        end
    end

endmodule

// File: tb/tb_l1_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_l1_port_arbiter
//
// Directed bench for l1_port_arbiter. A behavioural read-first RAM sits
// behind the memory port. Each accepted beat pushes its expected response
// (side, read data) to a scoreboard queue. The expected data comes from a
// reference memory kept by the bench. The entry is popped and compared in
// the cycle the DUT must respond.
// ----------------------------------------------------------------------------
module tb_l1_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req0_we, req0_lock;
    logic [AW-1:0] req0_addr;
    logic [BW-1:0] req0_be;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;
    logic          req1_valid, req1_ready, req1_we, req1_lock;
    logic [AW-1:0] req1_addr;
    logic [BW-1:0] req1_be;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit            side;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [int];

    always #5 clk = ~clk;

    l1_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_lock  (req0_lock),
        .req0_addr  (req0_addr),
        .req0_be    (req0_be),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_lock  (req1_lock),
        .req1_addr  (req1_addr),
        .req1_be    (req1_be),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Power-on contents: a distinct word per address.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'h5A00_0000 + {22'b0, a} * 32'h0001_0101;
    endfunction

    // Behavioural read-first RAM driven only by the DUT's memory port.
    logic [DW-1:0] env_ram     [0:(1<<AW)-1];
    bit            env_written [0:(1<<AW)-1];
    logic [DW-1:0] env_tmp;

    always @(posedge clk) begin
        if (mem_en) begin
            env_tmp = env_written[mem_addr] ? env_ram[mem_addr] : pat(mem_addr);
            mem_rdata <= env_tmp;
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) env_tmp[8*b +: 8] = mem_wdata[8*b +: 8];
                env_ram[mem_addr]     <= env_tmp;
                env_written[mem_addr] <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expected response of an accepted beat, then update the
    // reference memory (read-first: a write returns the old word).
    task automatic push(input bit side, input logic we, input logic [AW-1:0] addr,
                        input logic [BW-1:0] be, input logic [DW-1:0] wdata);
        logic [DW-1:0] old;
        old = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : pat(addr);
        sb.push_back('{side: side, data: old});
        if (we) begin
            logic [DW-1:0] nw;
            nw = old;
            for (int b = 0; b < BW; b++)
                if (be[b]) nw[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[int'(addr)] = nw;
        end
    endtask

    // One cycle with the inputs already driven at the preceding negedge.
    // Checks the grants and the memory drive, scores any accepted beat, and
    // checks the response one cycle later.
    task automatic beat(input string tag, input logic e0, input logic e1);
        exp_t e;
        #1;
        check({tag, " ready0"}, req0_ready, e0);
        check({tag, " ready1"}, req1_ready, e1);
        check({tag, " mem_en"}, mem_en, e0 | e1);
        if (e0) begin
            check({tag, " mem_addr"}, mem_addr, req0_addr);
            check({tag, " mem_we"}, mem_we, req0_we);
            if (req0_we) begin
                check({tag, " mem_be"}, mem_be, req0_be);
                check({tag, " mem_wdata"}, mem_wdata, req0_wdata);
            end
            push(1'b0, req0_we, req0_addr, req0_be, req0_wdata);
        end else if (e1) begin
            check({tag, " mem_addr"}, mem_addr, req1_addr);
            check({tag, " mem_we"}, mem_we, req1_we);
            if (req1_we) begin
                check({tag, " mem_be"}, mem_be, req1_be);
                check({tag, " mem_wdata"}, mem_wdata, req1_wdata);
            end
            push(1'b1, req1_we, req1_addr, req1_be, req1_wdata);
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " rsp0_valid"}, rsp0_valid, e.side == 1'b0);
            check({tag, " rsp1_valid"}, rsp1_valid, e.side == 1'b1);
            check({tag, " rsp_rdata"}, e.side ? rsp1_rdata : rsp0_rdata, e.data);
        end else begin
            check({tag, " rsp0_valid idle"}, rsp0_valid, 1'b0);
            check({tag, " rsp1_valid idle"}, rsp1_valid, 1'b0);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_lock = 1'b0;
        req0_addr  = '0;   req0_be = '1;   req0_wdata = 32'h1111_1111;
        req1_valid = 1'b1; req1_we = 1'b0; req1_lock = 1'b0;
        req1_addr  = '0;   req1_be = '1;   req1_wdata = 32'h2222_2222;

        // Reset state: requests present but nothing may be granted or issued.
        @(negedge clk);
        #1;
        check("reset ready0", req0_ready, 1'b0);
        check("reset ready1", req1_ready, 1'b0);
        check("reset mem_en", mem_en, 1'b0);
        check("reset mem_we", mem_we, 1'b0);
        check("reset rsp0_valid", rsp0_valid, 1'b0);
        check("reset rsp1_valid", rsp1_valid, 1'b0);
        @(negedge clk);
        reset      = 1'b0;
        req1_valid = 1'b0;

        // 1: lone req0 read of 0x005.
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h005;
        beat("t1 read", 1'b1, 1'b0);
        req0_valid = 1'b0;
        beat("t1 idle", 1'b0, 1'b0);

        // 2: both valid every cycle after reset -> grants 0,1,0,1.
        do_reset();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h020;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'h040;
        for (int i = 0; i < 4; i++) begin
            beat($sformatf("t2 rr%0d", i), (i % 2) == 0, (i % 2) == 1);
            if ((i % 2) == 0) req0_addr = req0_addr + 10'd1;
            else              req1_addr = req1_addr + 10'd1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // 3: partial write then read-back of 0x010.
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'h010;
        req0_be    = 4'b0011; req0_wdata = 32'hDEAD_BEEF;
        beat("t3 write", 1'b1, 1'b0);
        req0_we = 1'b0;
        beat("t3 read", 1'b1, 1'b0);
        req0_valid = 1'b0;

        // 4: pointer now favours req1; its locked 3-beat burst holds off req0.
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h030;
        req1_valid = 1'b1; req1_we = 1'b1; req1_be = 4'b1100;
        req1_addr  = 10'h050; req1_wdata = 32'hCAFE_0000; req1_lock = 1'b1;
        beat("t4 lock b0", 1'b0, 1'b1);
        req1_we = 1'b0; req1_addr = 10'h050;
        beat("t4 lock b1", 1'b0, 1'b1);
        req1_addr = 10'h051; req1_lock = 1'b0;
        beat("t4 lock b2", 1'b0, 1'b1);
        req1_valid = 1'b0;
        beat("t4 req0 after", 1'b1, 1'b0);
        req0_valid = 1'b0;

        // 6: LOCK0 with req0 idle for 5 cycles keeps req1 out.
        req0_valid = 1'b1; req0_lock = 1'b1; req0_addr = 10'h060;
        beat("t6 enter lock0", 1'b1, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'h070;
        for (int i = 0; i < 5; i++)
            beat($sformatf("t6 idle%0d", i), 1'b0, 1'b0);
        req0_valid = 1'b1; req0_lock = 1'b0; req0_addr = 10'h061;
        beat("t6 unlock", 1'b1, 1'b0);
        req0_valid = 1'b0;
        beat("t6 req1 after", 1'b0, 1'b1);
        req1_valid = 1'b0;

        // 5: reset in the cycle after a locked req1 read is accepted.
        req1_valid = 1'b1; req1_we = 1'b0; req1_lock = 1'b1; req1_addr = 10'h077;
        #1;
        check("t5 accept ready1", req1_ready, 1'b1);
        check("t5 accept mem_en", mem_en, 1'b1);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h078;
        #1;
        check("t5 rst rsp1_valid", rsp1_valid, 1'b0);
        check("t5 rst rsp0_valid", rsp0_valid, 1'b0);
        check("t5 rst mem_en", mem_en, 1'b0);
        check("t5 rst ready0", req0_ready, 1'b0);
        check("t5 rst ready1", req1_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        req1_lock = 1'b0;
        beat("t5 post rst", 1'b1, 1'b0);
        req0_valid = 1'b0;
        beat("t5 req1 read", 1'b0, 1'b1);
        req1_valid = 1'b0;
        beat("t5 drain", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
